// File: rtl/rcc_pkg.sv
// Shared types and constants for the RCC reset-flag / LSI-enable controller.
// Reset-source bit order is fixed here and mirrored by the RCC register file.
package rcc_pkg;

  typedef enum logic [1:0] {
    LSI_OFF      = 2'd0,
    LSI_STARTING = 2'd1,
    LSI_READY    = 2'd2,
    LSI_STOPPING = 2'd3
  } lsi_state_e;

  localparam int SRC_LPWR2 = 0;
  localparam int SRC_LPWR1 = 1;
  localparam int SRC_WWDG2 = 2;
  localparam int SRC_WWDG1 = 3;
  localparam int SRC_IWDG2 = 4;
  localparam int SRC_IWDG1 = 5;
  localparam int SRC_SFT2  = 6;
  localparam int SRC_SFT1  = 7;
  localparam int SRC_POR   = 8;
  localparam int SRC_BOR   = 9;
  localparam int SRC_PIN   = 10;
  localparam int SRC_CPU2  = 11;
  localparam int SRC_CPU1  = 12;
  localparam int SRC_OBL   = 13;

  localparam int NUM_SRC_DEF = 14;

  // A power-on always implies both POR and BOR as reset causes.
  localparam logic [NUM_SRC_DEF-1:0] RST_FLAG_INIT_DEF =
    NUM_SRC_DEF'((1 << SRC_POR) | (1 << SRC_BOR));

endpackage

// File: rtl/rcc_sync_edge.sv
// Multi-flop synchroniser for one asynchronous level, with a rising-edge pulse
// taken from the synchronised level and its one-clock-delayed copy.
module rcc_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q_sync,
  output logic q_rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q_sync = sync_q[SYNC_STAGES-1];
  assign q_rise = q_sync & ~dly_q;

endmodule

// File: rtl/rcc_rst_flag_ctrl.sv
// VDD-domain reset-flag and LSI-enable controller: per-CPU sticky reset-cause
// flags with RMVF clear, plus the LSION start/stop/timeout state machine.
module rcc_rst_flag_ctrl
  import rcc_pkg::*;
#(
  parameter int                 NUM_CPU       = 2,
  parameter int                 NUM_SRC       = NUM_SRC_DEF,
  parameter int                 SYNC_STAGES   = 2,
  parameter logic [NUM_SRC-1:0] RST_FLAG_INIT = NUM_SRC'(RST_FLAG_INIT_DEF),
  parameter int                 LSI_TMO       = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wdata,
  input  logic [NUM_CPU-1:0]         rmvf_wren,
  input  logic                       lsion_wren,
  input  logic [NUM_SRC-1:0]         rst_src,
  input  logic                       lsi_rdy,
  output logic [NUM_CPU*NUM_SRC-1:0] rsr_flags,
  output logic [NUM_CPU-1:0]         rmvf,
  output logic                       lsion,
  output logic                       lsirdy,
  output logic                       lsi_tmo,
  output logic [1:0]                 lsi_state
);

  localparam int               CNT_W    = $clog2(LSI_TMO + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LSI_TMO);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LSI_TMO - 1);

  // Only the rise of each source matters; the synchronised levels are spare.
  logic [NUM_SRC-1:0] src_lvl_unused;
  logic [NUM_SRC-1:0] src_rise;
  logic               rdy_s;
  logic               rdy_rise_unused;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    rcc_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .d      (rst_src[i]),
      .q_sync (src_lvl_unused[i]),
      .q_rise (src_rise[i])
    );
  end

  rcc_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_rdy_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (lsi_rdy),
    .q_sync (rdy_s),
    .q_rise (rdy_rise_unused)
  );

  for (genvar c = 0; c < NUM_CPU; c++) begin : g_cpu
    logic [NUM_SRC-1:0] flag_q, flag_d;
    logic               rmvf_q;

    // Clear wins over a coincident edge, so a cause seen while RMVF is set is lost.
    assign flag_d = rmvf_q ? '0 : (flag_q | src_rise);

    // NOTE: the flags reset to a non-zero cause pattern, not to zero, so that
    // software can read POR/BOR as the reason for the very first boot.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        flag_q <= RST_FLAG_INIT;
        rmvf_q <= 1'b0;
      end else begin
        flag_q <= flag_d;
        if (rmvf_wren[c]) rmvf_q <= wdata;
      end
    end

    assign rsr_flags[c*NUM_SRC +: NUM_SRC] = flag_q;
    assign rmvf[c]                         = rmvf_q;
  end

  lsi_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
  logic             lsion_q, lsirdy_q;
  logic             start_wr, stop_wr;

  assign start_wr = lsion_wren &  wdata;
  assign stop_wr  = lsion_wren & ~wdata;

  // NOTE: every next-state signal gets its hold value first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    case (state_q)
      LSI_OFF: begin
        if (start_wr) begin
          state_d = LSI_STARTING;
          cnt_d   = '0;
          tmo_d   = 1'b0;
        end
      end
      LSI_STARTING: begin
        if (stop_wr) begin
          state_d = LSI_STOPPING;
        end else if (rdy_s) begin
          state_d = LSI_READY;
        end else begin
          if (cnt_q == CNT_LAST) tmo_d = 1'b1;
          if (cnt_q != CNT_MAX)  cnt_d = cnt_q + 1'b1;
        end
      end
      LSI_READY: begin
        if (stop_wr) begin
          state_d = LSI_STOPPING;
        end else if (!rdy_s) begin
          state_d = LSI_STARTING;
          cnt_d   = '0;
        end
      end
      LSI_STOPPING: begin
        if (start_wr) begin
          state_d = LSI_STARTING;
          cnt_d   = '0;
          tmo_d   = 1'b0;
        end else if (!rdy_s) begin
          state_d = LSI_OFF;
        end
      end
      default: state_d = LSI_OFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LSI_OFF;
      cnt_q    <= '0;
      tmo_q    <= 1'b0;
      lsion_q  <= 1'b0;
      lsirdy_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      lsion_q  <= (state_d == LSI_STARTING) || (state_d == LSI_READY);
      lsirdy_q <= (state_d == LSI_READY);
    end
  end

  assign lsion     = lsion_q;
  assign lsirdy    = lsirdy_q;
  assign lsi_tmo   = tmo_q;
  assign lsi_state = state_q;

endmodule

// File: tb/tb_rcc_rst_flag_ctrl.sv
// Self-checking bench for rcc_rst_flag_ctrl: directed scenarios plus a random
// run compared cycle by cycle against a delayed-sample behavioural model.
module tb_rcc_rst_flag_ctrl;

  localparam int NUM_CPU = 2;
  localparam int NUM_SRC = 14;
  localparam int SYNC    = 2;
  localparam int TMO     = 16;
  localparam int OUT_W   = NUM_CPU*NUM_SRC + NUM_CPU + 5;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic                       wdata = 1'b0;
  logic [NUM_CPU-1:0]         rmvf_wren = '0;
  logic                       lsion_wren = 1'b0;
  logic [NUM_SRC-1:0]         rst_src = '0;
  logic                       lsi_rdy = 1'b0;
  logic [NUM_CPU*NUM_SRC-1:0] rsr_flags;
  logic [NUM_CPU-1:0]         rmvf;
  logic                       lsion, lsirdy, lsi_tmo;
  logic [1:0]                 lsi_state;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rcc_rst_flag_ctrl #(
    .NUM_CPU(NUM_CPU), .NUM_SRC(NUM_SRC), .SYNC_STAGES(SYNC),
    .RST_FLAG_INIT(14'h0300), .LSI_TMO(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wdata(wdata), .rmvf_wren(rmvf_wren),
    .lsion_wren(lsion_wren), .rst_src(rst_src), .lsi_rdy(lsi_rdy),
    .rsr_flags(rsr_flags), .rmvf(rmvf), .lsion(lsion), .lsirdy(lsirdy),
    .lsi_tmo(lsi_tmo), .lsi_state(lsi_state)
  );

  // Reference model: a source edge reaches the flags SYNC samples late; the
  // history queues hold the last SYNC+1 pre-edge samples (oldest first).
  logic [NUM_SRC-1:0] m_flags [NUM_CPU];
  logic [NUM_CPU-1:0] m_rmvf;
  int                 m_state, m_cnt;
  logic               m_tmo;
  logic [NUM_SRC-1:0] src_hist [$];
  logic               rdy_hist [$];

  task automatic model_reset();
    for (int c = 0; c < NUM_CPU; c++) m_flags[c] = 14'h0300;
    m_rmvf = '0; m_state = 0; m_cnt = 0; m_tmo = 1'b0;
    src_hist.delete(); rdy_hist.delete();
    for (int i = 0; i <= SYNC; i++) begin
      src_hist.push_back('0);
      rdy_hist.push_back(1'b0);
    end
  endtask

  task automatic model_update();
    logic [NUM_SRC-1:0] rise;
    logic               rdy;
    rise = src_hist[1] & ~src_hist[0];
    rdy  = rdy_hist[1];
    for (int c = 0; c < NUM_CPU; c++) begin
      m_flags[c] = m_rmvf[c] ? '0 : (m_flags[c] | rise);
      if (rmvf_wren[c]) m_rmvf[c] = wdata;
    end
    case (m_state)
      0: if (lsion_wren && wdata) begin m_state = 1; m_cnt = 0; m_tmo = 1'b0; end
      1: begin
        if (lsion_wren && !wdata) m_state = 3;
        else if (rdy) m_state = 2;
        else begin
          if (m_cnt == TMO - 1) m_tmo = 1'b1;
          if (m_cnt < TMO) m_cnt++;
        end
      end
      2: begin
        if (lsion_wren && !wdata) m_state = 3;
        else if (!rdy) begin m_state = 1; m_cnt = 0; end
      end
      default: begin
        if (lsion_wren && wdata) begin m_state = 1; m_cnt = 0; m_tmo = 1'b0; end
        else if (!rdy) m_state = 0;
      end
    endcase
    src_hist.push_back(rst_src); void'(src_hist.pop_front());
    rdy_hist.push_back(lsi_rdy); void'(rdy_hist.pop_front());
  endtask

  function automatic logic [OUT_W-1:0] model_vec();
    logic [NUM_CPU*NUM_SRC-1:0] f;
    for (int c = 0; c < NUM_CPU; c++) f[c*NUM_SRC +: NUM_SRC] = m_flags[c];
    return {f, m_rmvf, (m_state == 1 || m_state == 2), (m_state == 2), m_tmo, 2'(m_state)};
  endfunction

  function automatic logic [OUT_W-1:0] dut_vec();
    return {rsr_flags, rmvf, lsion, lsirdy, lsi_tmo, lsi_state};
  endfunction

  function automatic logic [OUT_W-1:0] pack(input logic [13:0] f1, input logic [13:0] f0,
      input logic [1:0] rm, input logic on, input logic rdy, input logic tmo, input logic [1:0] st);
    return {f1, f0, rm, on, rdy, tmo, st};
  endfunction

  // One clock: inputs are sampled at the edge, outputs settle 2 ns later.
  task automatic step();
    @(posedge clk);
    model_update();
    #2;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; wdata = 1'b0; rmvf_wren = '0; lsion_wren = 1'b0;
    rst_src = '0; lsi_rdy = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [OUT_W-1:0] exp;
    apply_reset();
    exp = pack(14'h0300, 14'h0300, 2'b00, 0, 0, 0, 2'd0);
    checks++; if (dut_vec() !== exp) begin failures++; $display("FAIL reset_values got=%h exp=%h", dut_vec(), exp); end
    step();
    checks++; if (dut_vec() !== exp) begin failures++; $display("FAIL reset_idle got=%h exp=%h", dut_vec(), exp); end
  endtask

  task automatic test_src_edge();
    logic [OUT_W-1:0] exp;
    apply_reset();
    rst_src = 14'h0008;
    step(); step();
    exp = pack(14'h0300, 14'h0300, 2'b00, 0, 0, 0, 2'd0);
    checks++; if (dut_vec() !== exp) begin failures++; $display("FAIL src_before_set got=%h exp=%h", dut_vec(), exp); end
    step();
    exp = pack(14'h0308, 14'h0308, 2'b00, 0, 0, 0, 2'd0);
    checks++; if (dut_vec() !== exp) begin failures++; $display("FAIL src_set_3clk got=%h exp=%h", dut_vec(), exp); end
    step(); step();
    rmvf_wren = 2'b11; wdata = 1'b1; step(); rmvf_wren = '0; wdata = 1'b0;
    exp = pack(14'h0308, 14'h0308, 2'b11, 0, 0, 0, 2'd0);
    checks++; if (dut_vec() !== exp) begin failures++; $display("FAIL rmvf_write_cycle got=%h exp=%h", dut_vec(), exp); end
    step();
    exp = pack(14'h0000, 14'h0000, 2'b11, 0, 0, 0, 2'd0);
    checks++; if (dut_vec() !== exp) begin failures++; $display("FAIL rmvf_clear got=%h exp=%h", dut_vec(), exp); end
    rmvf_wren = 2'b11; wdata = 1'b0; step(); rmvf_wren = '0;
    repeat (6) step();
    exp = pack(14'h0000, 14'h0000, 2'b00, 0, 0, 0, 2'd0);
    checks++; if (dut_vec() !== exp) begin failures++; $display("FAIL held_no_second_edge got=%h exp=%h", dut_vec(), exp); end
    rst_src = '0; repeat (3) step();
    rst_src = 14'h0008; repeat (3) step();
    exp = pack(14'h0008, 14'h0008, 2'b00, 0, 0, 0, 2'd0);
    checks++; if (dut_vec() !== exp) begin failures++; $display("FAIL src_re_edge got=%h exp=%h", dut_vec(), exp); end
    rst_src = '0;
  endtask

  task automatic test_rmvf();
    logic [OUT_W-1:0] exp;
    apply_reset();
    rmvf_wren = 2'b01; wdata = 1'b1; step(); rmvf_wren = '0; wdata = 1'b0;
    step();
    rst_src = 14'h0020; step(); step(); rst_src = '0;
    repeat (4) step();
    exp = pack(14'h0320, 14'h0000, 2'b01, 0, 0, 0, 2'd0);
    checks++; if (dut_vec() !== exp) begin failures++; $display("FAIL rmvf_edge_lost got=%h exp=%h", dut_vec(), exp); end
    rmvf_wren = 2'b01; wdata = 1'b0; step(); rmvf_wren = '0; step();
    exp = pack(14'h0320, 14'h0000, 2'b00, 0, 0, 0, 2'd0);
    checks++; if (dut_vec() !== exp) begin failures++; $display("FAIL rmvf_release got=%h exp=%h", dut_vec(), exp); end
    rst_src = 14'h0080; step(); step();
    rmvf_wren = 2'b10; wdata = 1'b1; step(); rmvf_wren = '0; wdata = 1'b0;
    exp = pack(14'h03a0, 14'h0080, 2'b10, 0, 0, 0, 2'd0);
    checks++; if (dut_vec() !== exp) begin failures++; $display("FAIL same_clk_set got=%h exp=%h", dut_vec(), exp); end
    step();
    exp = pack(14'h0000, 14'h0080, 2'b10, 0, 0, 0, 2'd0);
    checks++; if (dut_vec() !== exp) begin failures++; $display("FAIL same_clk_clear got=%h exp=%h", dut_vec(), exp); end
    rst_src = '0;
  endtask

  task automatic test_lsi_start();
    logic [OUT_W-1:0] exp;
    apply_reset();
    lsion_wren = 1'b1; wdata = 1'b1; step(); lsion_wren = 1'b0; wdata = 1'b0;
    exp = pack(14'h0300, 14'h0300, 2'b00, 1, 0, 0, 2'd1);
    checks++; if (dut_vec() !== exp) begin failures++; $display("FAIL lsi_starting got=%h exp=%h", dut_vec(), exp); end
    for (int i = 1; i <= 12; i++) begin
      step();
      if (i == 9) lsi_rdy = 1'b1;
      if (i == 11) begin
        checks++; if (dut_vec() !== exp) begin failures++; $display("FAIL lsi_not_ready_yet got=%h exp=%h", dut_vec(), exp); end
      end
    end
    exp = pack(14'h0300, 14'h0300, 2'b00, 1, 1, 0, 2'd2);
    checks++; if (dut_vec() !== exp) begin failures++; $display("FAIL lsi_ready_at_12 got=%h exp=%h", dut_vec(), exp); end
    lsi_rdy = 1'b0; repeat (3) step();
    exp = pack(14'h0300, 14'h0300, 2'b00, 1, 0, 0, 2'd1);
    checks++; if (dut_vec() !== exp) begin failures++; $display("FAIL lsi_osc_loss got=%h exp=%h", dut_vec(), exp); end
  endtask

  task automatic test_lsi_timeout();
    logic [OUT_W-1:0] exp;
    apply_reset();
    lsion_wren = 1'b1; wdata = 1'b1; step(); lsion_wren = 1'b0; wdata = 1'b0;
    repeat (15) step();
    exp = pack(14'h0300, 14'h0300, 2'b00, 1, 0, 0, 2'd1);
    checks++; if (dut_vec() !== exp) begin failures++; $display("FAIL tmo_not_yet got=%h exp=%h", dut_vec(), exp); end
    step();
    exp = pack(14'h0300, 14'h0300, 2'b00, 1, 0, 1, 2'd1);
    checks++; if (dut_vec() !== exp) begin failures++; $display("FAIL tmo_at_16 got=%h exp=%h", dut_vec(), exp); end
    repeat (5) step();
    checks++; if (dut_vec() !== exp) begin failures++; $display("FAIL tmo_sticky got=%h exp=%h", dut_vec(), exp); end
    lsion_wren = 1'b1; wdata = 1'b0; step(); lsion_wren = 1'b0;
    exp = pack(14'h0300, 14'h0300, 2'b00, 0, 0, 1, 2'd3);
    checks++; if (dut_vec() !== exp) begin failures++; $display("FAIL lsi_stopping got=%h exp=%h", dut_vec(), exp); end
    step();
    exp = pack(14'h0300, 14'h0300, 2'b00, 0, 0, 1, 2'd0);
    checks++; if (dut_vec() !== exp) begin failures++; $display("FAIL lsi_off got=%h exp=%h", dut_vec(), exp); end
    lsion_wren = 1'b1; wdata = 1'b1; step(); lsion_wren = 1'b0; wdata = 1'b0;
    exp = pack(14'h0300, 14'h0300, 2'b00, 1, 0, 0, 2'd1);
    checks++; if (dut_vec() !== exp) begin failures++; $display("FAIL lsi_restart_clears_tmo got=%h exp=%h", dut_vec(), exp); end
  endtask

  task automatic test_async_reset();
    logic [OUT_W-1:0] exp;
    apply_reset();
    rst_src = 14'h0001; lsi_rdy = 1'b1;
    lsion_wren = 1'b1; wdata = 1'b1; step(); lsion_wren = 1'b0; wdata = 1'b0;
    repeat (4) step();
    exp = pack(14'h0301, 14'h0301, 2'b00, 1, 1, 0, 2'd2);
    checks++; if (dut_vec() !== exp) begin failures++; $display("FAIL pre_reset_ready got=%h exp=%h", dut_vec(), exp); end
    #1 rst_n = 1'b0;
    #1;
    exp = pack(14'h0300, 14'h0300, 2'b00, 0, 0, 0, 2'd0);
    checks++; if (dut_vec() !== exp) begin failures++; $display("FAIL async_reset got=%h exp=%h", dut_vec(), exp); end
    apply_reset();
  endtask

  task automatic test_random();
    int fails_shown = 0;
    apply_reset();
    for (int n = 0; n < 3000; n++) begin
      wdata = 1'($urandom_range(0, 1));
      for (int c = 0; c < NUM_CPU; c++) rmvf_wren[c] = ($urandom_range(0, 15) == 0);
      lsion_wren = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < NUM_SRC; i++) if ($urandom_range(0, 7) == 0) rst_src[i] = ~rst_src[i];
      if ($urandom_range(0, 23) == 0) lsi_rdy = ~lsi_rdy;
      step();
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++;
        if (fails_shown < 10) $display("FAIL random_cycle_%0d got=%h exp=%h", n, dut_vec(), model_vec());
        fails_shown++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_src_edge();
    test_rmvf();
    test_lsi_start();
    test_lsi_timeout();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
